muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Sequencer for the CPU's shared multiply/divide resource. Accepts a single mult or div request from the control unit, fires the matching one-cycle start pulse into the `mult` or `div` unit, and counts the fixed iteration latency. On completion it drives the HI/LO source select and write enables, and reports completion, busy or divide-by-zero back to the control unit, which stalls while `busy` is high.

## Interface
Parameters:
- `MULT_CYCLES`, default 32: cycles the `mult` unit needs after its start pulse before HI/LO outputs are valid.
- `DIV_CYCLES`, default 32: same, for the `div` unit.
- `CW`, default $clog2(max(MULT_CYCLES,DIV_CYCLES)): width of the internal cycle counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `op_valid` in 1: request strobe, sampled only in IDLE.
- `op_type` in 1: 0 = DIV, 1 = MULT; sampled with `op_valid`.
- `divisor` in 32: B operand, checked for zero at accept.
- `cancel` in 1: abort an in-flight operation (exception flush).
- `mult_start` out 1: one-cycle start pulse to `mult`.
- `div_start` out 1: one-cycle start pulse to `div`.
- `HiLoSrc` out 1: HI/LO mux select; 0 = div outputs, 1 = mult outputs.
- `HI_write` out 1: HI register write enable.
- `LO_write` out 1: LO register write enable.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse, coincident with the HI/LO write.
- `divzero_exc` out 1: one-cycle pulse when a DIV is rejected because the divisor is zero.

## Operation
- States: IDLE, START, RUN, WRITE, EXC. All outputs are Moore, decoded from the registered state and the registered `op_reg`.
- IDLE:
  - `op_valid`=1 and `cancel`=0: latch `op_reg`=`op_type`.
  - If DIV and `divisor`==0, go to EXC; otherwise go to START.
  - `op_valid` with `cancel`=1 is dropped and the state stays IDLE.
- START:
  - `mult_start`=`op_reg`, `div_start`=~`op_reg`.
  - Load the counter with (`op_reg` ? `MULT_CYCLES` : `DIV_CYCLES`) - 1, then go to RUN.
- RUN: decrement the counter each cycle. When the counter is 0, go to WRITE.
- WRITE: `HI_write`=`LO_write`=1, `done`=1, then go to IDLE.
- EXC: `divzero_exc`=1; no start pulse and no HI/LO write. Go to IDLE.
- `HiLoSrc` = `op_reg` in every state and holds its value after the operation.
- `cancel`:
  - In START or RUN: go to IDLE at the next edge, with no write and no `done`. The unit's internal state is abandoned, because the next start pulse reinitialises it.
  - In WRITE or EXC: ignored; that state completes.
- `op_valid` outside IDLE is ignored. The requester must hold it until `busy` is seen low.

## Timing
- Reset (`reset`=0): state goes to IDLE, counter and `op_reg` clear to 0, and all outputs are 0 immediately, asynchronously. Asserting reset mid-operation discards the operation with no write.
- Accept at edge E0. START occupies cycle 1, RUN occupies cycles 2..N+1, and WRITE occupies cycle N+2, where N is the latency for the op.
  - HI/LO capture at the edge ending cycle N+2.
  - `busy` goes low in cycle N+3.
  - With N=32: `done` is high in cycle 34.
- A back-to-back request can be accepted at the edge ending cycle N+3, at the earliest. Throughput is therefore one op per N+3 cycles.
- Divide-by-zero: EXC occupies cycle 1 and `busy` goes low in cycle 2.
- `mult_start`, `div_start`, `HI_write`, `LO_write`, `done` and `divzero_exc` are each exactly one cycle wide and never overlap.

## Structure
- Package `muldiv_pkg`: state enum (IDLE, START, RUN, WRITE, EXC), and constants `OP_DIV`=0, `OP_MULT`=1.
- Sub-module `muldiv_cycle_counter`: loadable down-counter of width `CW` with `load`, `load_val`, `en`, and a `zero` flag; cleared by the asynchronous reset.
- The top module contains the state register, the `op_reg` latch and the output decode only.

## Test plan
- MULT, default parameters: `op_valid`=1, `op_type`=1, `divisor`=5 at E0 → `mult_start` high in cycle 1 only; `HI_write`/`LO_write`/`done` high in cycle 34 only, with `HiLoSrc`=1; `busy` high in cycles 1–34.
- DIV with `divisor`=0 → `divzero_exc` high in cycle 1; `div_start`, `HI_write` and `LO_write` stay 0 throughout; `busy` is 0 in cycle 2.
- DIV with `divisor`=7, then `cancel` in RUN at cycle 10 → IDLE at cycle 11; no `done` and no write; a new MULT accepted at cycle 11 completes normally.
- `reset` pulled low during RUN → all outputs 0 within the same cycle; after release, `busy`=0 and `HiLoSrc`=0.
- `op_valid` held high continuously with MULT_CYCLES=4 → accepts at cycle 0 and cycle 7; `done` in cycles 6 and 13; requests seen while busy are ignored.
- `cancel` during WRITE → the write and `done` still occur.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the multiply/divide sequencer.
//   state_e  - sequencer FSM states
//   OP_DIV / OP_MULT - encoding of op_type / op_reg / HiLoSrc
package muldiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_WRITE = 3'd3,
    S_EXC   = 3'd4
  } state_e;

  localparam logic OP_DIV  = 1'b0;
  localparam logic OP_MULT = 1'b1;

endpackage

// File: rtl/muldiv_cycle_counter.sv
// muldiv_cycle_counter: loadable down-counter timing the mult/div latency.
//   clk, reset   - clock, asynchronous active-low reset (clears count)
//   load         - load load_val (has priority over en)
//   load_val     - value to load
//   en           - decrement by one
//   zero         - count is zero
module muldiv_cycle_counter #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          zero
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    cnt_q <= '0;
    else if (load) cnt_q <= load_val;
    else if (en)   cnt_q <= cnt_q - 1'b1;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: issues start pulses to the shared mult/div units, times
// their fixed latency and drives the HI/LO write-back.
//   clk, reset      - clock, asynchronous active-low reset
//   op_valid        - request strobe (only looked at in IDLE)
//   op_type         - 0 = DIV, 1 = MULT
//   divisor         - B operand, tested for zero when a DIV is accepted
//   cancel          - flush an op in START/RUN
//   mult_start      - one-cycle start pulse to mult
//   div_start       - one-cycle start pulse to div
//   HiLoSrc         - HI/LO source select (1 = mult), follows op_reg
//   HI_write        - HI write enable
//   LO_write        - LO write enable
//   busy            - high outside IDLE (control unit stalls on it)
//   done            - completion pulse, coincident with the HI/LO write
//   divzero_exc     - pulse when a DIV by zero is rejected
// All outputs are decoded from registered state only, so reset forces them
// low immediately.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CW = $clog2((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_type,
  input  logic [31:0] divisor,
  input  logic        cancel,
  output logic        mult_start,
  output logic        div_start,
  output logic        HiLoSrc,
  output logic        HI_write,
  output logic        LO_write,
  output logic        busy,
  output logic        done,
  output logic        divzero_exc
);

  // A latency of 1 gives CW = 0; keep the counter at least one bit wide.
  localparam int CNT_W = (CW < 1) ? 1 : CW;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_e state_q, state_d;
  logic   op_q, op_d;
  logic   cnt_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_DIV;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE: begin
        // A request arriving together with a flush is dropped.
        if (op_valid && !cancel) begin
          op_d    = op_type;
          state_d = (op_type == OP_DIV && divisor == '0) ? S_EXC : S_START;
        end
      end
      S_START: state_d = cancel ? S_IDLE : S_RUN;
      S_RUN: begin
        if (cancel)        state_d = S_IDLE;
        else if (cnt_zero) state_d = S_WRITE;
      end
      // Write-back and exception report always complete.
      S_WRITE: state_d = S_IDLE;
      S_EXC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Loaded with N-1 in START so RUN spans N cycles; on cancel the count is
  // left stale since the next START reloads it.
  muldiv_cycle_counter #(.CW(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (state_q == S_START),
    .load_val ((op_q == OP_MULT) ? MULT_LOAD : DIV_LOAD),
    .en       (state_q == S_RUN && !cnt_zero),
    .zero     (cnt_zero)
  );

  assign mult_start  = (state_q == S_START) &&  op_q;
  assign div_start   = (state_q == S_START) && !op_q;
  assign HiLoSrc     = op_q;
  assign HI_write    = (state_q == S_WRITE);
  assign LO_write    = (state_q == S_WRITE);
  assign done        = (state_q == S_WRITE);
  assign divzero_exc = (state_q == S_EXC);
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a vector table of single ops with
// expected pulse cycles, plus hand-written multi-cycle sequences.
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic op_valid, op_type, cancel;
  logic [31:0] divisor;
  logic mult_start, div_start, HiLoSrc, HI_write, LO_write, busy, done, divzero_exc;

  logic ov4, ot4, cn4;
  logic [31:0] dv4;
  logic ms4, ds4, hl4, hw4, lw4, bz4, dn4, ex4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_type(op_type),
    .divisor(divisor), .cancel(cancel), .mult_start(mult_start),
    .div_start(div_start), .HiLoSrc(HiLoSrc), .HI_write(HI_write),
    .LO_write(LO_write), .busy(busy), .done(done), .divzero_exc(divzero_exc)
  );

  muldiv_sequencer #(.MULT_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .op_valid(ov4), .op_type(ot4),
    .divisor(dv4), .cancel(cn4), .mult_start(ms4),
    .div_start(ds4), .HiLoSrc(hl4), .HI_write(hw4),
    .LO_write(lw4), .busy(bz4), .done(dn4), .divzero_exc(ex4)
  );

  typedef struct {
    string       name;
    logic        op;
    logic [31:0] dvs;
    int          cancel_c;  // cycle in which cancel is high, -1 none
    int          ms_c, ds_c, wr_c, ex_c;  // expected pulse cycle, -1 none
    int          busy_hi;   // busy expected high in cycles 1..busy_hi
    logic        hilo;      // HiLoSrc expected at the end
  } vec_t;

  vec_t vt[11];

  // Per-cycle bitmaps of observed outputs, bit c = cycle c after accept.
  logic [63:0] m_ms, m_ds, m_hi, m_lo, m_dn, m_ex, m_bz, m_ov;
  logic        hl_end;

  function automatic logic [63:0] bm(int c);
    return (c < 0) ? 64'd0 : (64'd1 << c);
  endfunction

  function automatic logic [63:0] rng(int lo, int hi);
    logic [63:0] r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic vec_t mk(string n, logic op, logic [31:0] d, int cc,
                              int ms, int ds, int wr, int ex, int bh, logic hl);
    vec_t v;
    v.name = n; v.op = op; v.dvs = d; v.cancel_c = cc;
    v.ms_c = ms; v.ds_c = ds; v.wr_c = wr; v.ex_c = ex; v.busy_hi = bh; v.hilo = hl;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge (cycle 0): presents op, then records n cycles.
  task automatic watch(input logic op, input logic [31:0] dv, input int n,
                       input int cancel_c, input int op2_c, input logic op2);
    m_ms = '0; m_ds = '0; m_hi = '0; m_lo = '0;
    m_dn = '0; m_ex = '0; m_bz = '0; m_ov = '0;
    op_valid = 1'b1; op_type = op; divisor = dv; cancel = (cancel_c == 0);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      m_ms[c] = mult_start; m_ds[c] = div_start; m_hi[c] = HI_write;
      m_lo[c] = LO_write;   m_dn[c] = done;      m_ex[c] = divzero_exc;
      m_bz[c] = busy;
      if (int'(mult_start) + int'(div_start) + int'(done) + int'(divzero_exc) > 1)
        m_ov[c] = 1'b1;
      cancel   = (c == cancel_c);
      op_valid = (c == op2_c);
      if (c == op2_c) begin op_type = op2; divisor = 32'd1; end
    end
    hl_end = HiLoSrc;
    cancel = 1'b0; op_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] n_ms, n_dn, n_hw, n_bz;
    int wr_cnt, bz_cnt;

    vt[0]  = mk("mult",          1'b1, 32'd5,          -1,  1, -1, 34, -1, 34, 1'b1);
    vt[1]  = mk("div",           1'b0, 32'd7,          -1, -1,  1, 34, -1, 34, 1'b0);
    vt[2]  = mk("div0",          1'b0, 32'd0,          -1, -1, -1, -1,  1,  1, 1'b0);
    vt[3]  = mk("mult_b0",       1'b1, 32'd0,          -1,  1, -1, 34, -1, 34, 1'b1);
    vt[4]  = mk("div_cancel10",  1'b0, 32'd7,          10, -1,  1, -1, -1, 10, 1'b0);
    vt[5]  = mk("mult_cancel33", 1'b1, 32'd3,          33,  1, -1, -1, -1, 33, 1'b1);
    vt[6]  = mk("mult_cancelwr", 1'b1, 32'd3,          34,  1, -1, 34, -1, 34, 1'b1);
    vt[7]  = mk("mult_cancelst", 1'b1, 32'd3,           1,  1, -1, -1, -1,  1, 1'b1);
    vt[8]  = mk("div0_cancel",   1'b0, 32'd0,           1, -1, -1, -1,  1,  1, 1'b0);
    vt[9]  = mk("div_msb",       1'b0, 32'h8000_0000,  -1, -1,  1, 34, -1, 34, 1'b0);
    vt[10] = mk("div_cancel2",   1'b0, 32'd9,           2, -1,  1, -1, -1,  2, 1'b0);

    reset = 1'b0; op_valid = 1'b0; op_type = 1'b0; divisor = '0; cancel = 1'b0;
    ov4 = 1'b0; ot4 = 1'b0; dv4 = '0; cn4 = 1'b0;
    #1;
    chk("reset_outs", 64'({mult_start, div_start, HiLoSrc, HI_write, LO_write,
                           busy, done, divzero_exc}), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // Table of single operations, 40-cycle observation window each.
    foreach (vt[i]) begin
      watch(vt[i].op, vt[i].dvs, 40, vt[i].cancel_c, -1, 1'b0);
      chk({vt[i].name, "_mstart"}, m_ms, bm(vt[i].ms_c));
      chk({vt[i].name, "_dstart"}, m_ds, bm(vt[i].ds_c));
      chk({vt[i].name, "_hiwr"},   m_hi, bm(vt[i].wr_c));
      chk({vt[i].name, "_lowr"},   m_lo, bm(vt[i].wr_c));
      chk({vt[i].name, "_done"},   m_dn, bm(vt[i].wr_c));
      chk({vt[i].name, "_exc"},    m_ex, bm(vt[i].ex_c));
      chk({vt[i].name, "_busy"},   m_bz, rng(1, vt[i].busy_hi));
      chk({vt[i].name, "_ovl"},    m_ov, 64'd0);
      chk({vt[i].name, "_hilo"},   64'(hl_end), 64'(vt[i].hilo));
    end

    // Request with cancel in IDLE is dropped; HiLoSrc keeps prior DIV value.
    op_valid = 1'b1; op_type = 1'b1; divisor = 32'd3; cancel = 1'b1;
    @(negedge clk);
    chk("drop_busy", 64'(busy), 64'd0);
    op_valid = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("drop_state", 64'({mult_start, busy, HiLoSrc}), 64'd0);

    // DIV cancelled in cycle 10, MULT accepted at the end of cycle 11.
    watch(1'b0, 32'd7, 50, 10, 11, 1'b1);
    chk("chain_dstart", m_ds, bm(1));
    chk("chain_mstart", m_ms, bm(12));
    chk("chain_done",   m_dn, bm(45));
    chk("chain_hiwr",   m_hi, bm(45));
    chk("chain_busy",   m_bz, rng(1, 10) | rng(12, 45));
    chk("chain_hilo",   64'(hl_end), 64'd1);

    // Reset asserted during RUN.
    watch(1'b1, 32'd5, 10, -1, -1, 1'b0);
    chk("rst_pre_busy", m_bz, rng(1, 10));
    reset = 1'b0;
    #1;
    chk("rst_async_outs", 64'({mult_start, div_start, HiLoSrc, HI_write, LO_write,
                               busy, done, divzero_exc}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    wr_cnt = 0; bz_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      wr_cnt += int'(HI_write) + int'(LO_write) + int'(done);
      bz_cnt += int'(busy);
    end
    chk("rst_no_write", 64'(wr_cnt), 64'd0);
    chk("rst_no_busy",  64'(bz_cnt), 64'd0);
    chk("rst_hilo",     64'(HiLoSrc), 64'd0);

    // MULT_CYCLES=4 with op_valid held: accepts end of cycles 0 and 7.
    n_ms = '0; n_dn = '0; n_hw = '0; n_bz = '0;
    ov4 = 1'b1; ot4 = 1'b1; dv4 = 32'd9;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      n_ms[c] = ms4; n_dn[c] = dn4; n_hw[c] = hw4 & lw4; n_bz[c] = bz4;
      if (c == 12) ov4 = 1'b0;
    end
    chk("b2b_mstart", n_ms, bm(1) | bm(8));
    chk("b2b_done",   n_dn, bm(6) | bm(13));
    chk("b2b_write",  n_hw, bm(6) | bm(13));
    chk("b2b_busy",   n_bz, rng(1, 6) | rng(8, 13));
    chk("b2b_hilo",   64'(hl4), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
